// File: rtl/scan_index_window_pkg.sv
// rtl/scan_index_window_pkg.sv - shared constants, state type and window test for scan_index_window
package scan_index_window_pkg;

    localparam int INDEX_MAX_DEFAULT = 7200;

    localparam logic [15:0] DEF_START_INDEX = 16'd0;
    localparam logic [15:0] DEF_STOP_INDEX  = 16'd3599;
    localparam logic [15:0] DEF_INDEX_NUM   = 16'd3600;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } win_state_t;

    // A window with start > stop wraps through index 0.
    function automatic logic in_window(input logic [15:0] idx,
                                       input logic [15:0] start,
                                       input logic [15:0] stop);
        if (start <= stop)
            return (idx >= start) && (idx <= stop);
        else
            return (idx >= start) || (idx <= stop);
    endfunction

endpackage

// File: rtl/scan_index_window_out_reg.sv
// rtl/scan_index_window_out_reg.sv - one-deep valid/ready output register for windowed points
module win_out_reg #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_sof,
    input  logic              i_eof,
    input  logic [15:0]       i_index,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic              o_sof,
    output logic              o_eof,
    output logic [15:0]       o_index,
    output logic [DATA_W-1:0] o_data
);

    // Load a new point or drain the held one; fields stay frozen while stalled.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_sof   <= 1'b0;
            o_eof   <= 1'b0;
            o_index <= '0;
            o_data  <= '0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_sof   <= i_sof;
            o_eof   <= i_eof;
            o_index <= i_index;
            o_data  <= i_data;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/scan_index_window.sv
// rtl/scan_index_window.sv - forwards in-window scan points, capped per frame, with sof/eof marking
module scan_index_window
    import scan_index_window_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int INDEX_MAX = INDEX_MAX_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [15:0]       i_start_index,
    input  logic [15:0]       i_stop_index,
    input  logic [15:0]       i_index_num,
    input  logic              i_pt_valid,
    input  logic              i_pt_sof,
    input  logic [DATA_W-1:0] i_pt_data,
    output logic              o_pt_ready,
    output logic              o_win_valid,
    output logic              o_win_sof,
    output logic              o_win_eof,
    output logic [15:0]       o_win_index,
    output logic [DATA_W-1:0] o_win_data,
    input  logic              i_win_ready,
    output logic [15:0]       o_frame_cnt,
    output logic              o_short_err
);

    localparam logic [15:0] IDX_LIMIT = 16'(INDEX_MAX);

    win_state_t  state_q, state_d;
    logic [15:0] start_q, stop_q, num_q;
    logic [15:0] idx_next_q, emit_cnt_q, emit_cnt_d, frame_cnt_q;
    logic        short_q;

    logic        pt_xfer;
    logic [15:0] cur_idx, eff_start, eff_stop, eff_num, eff_cnt;
    logic        emit, last;

    assign o_pt_ready = !o_win_valid || i_win_ready;
    assign pt_xfer    = i_pt_valid && o_pt_ready;

    // A sof point is judged against the config it carries, not the old shadow.
    assign cur_idx   = i_pt_sof ? 16'd0 : idx_next_q;
    assign eff_start = i_pt_sof ? i_start_index : start_q;
    assign eff_stop  = i_pt_sof ? i_stop_index  : stop_q;
    assign eff_num   = i_pt_sof ? i_index_num   : num_q;
    assign eff_cnt   = i_pt_sof ? 16'd0         : emit_cnt_q;

    // Frame state and emit decision for the point being transferred.
    always_comb begin
        state_d    = state_q;
        emit_cnt_d = emit_cnt_q;
        emit       = 1'b0;
        last       = 1'b0;
        if (pt_xfer) begin
            if (i_pt_sof) begin
                state_d    = ST_STREAM;
                emit_cnt_d = 16'd0;
            end
            if (state_d == ST_STREAM && cur_idx < IDX_LIMIT &&
                in_window(cur_idx, eff_start, eff_stop) && eff_cnt < eff_num) begin
                emit       = 1'b1;
                last       = (eff_cnt + 16'd1) == eff_num;
                emit_cnt_d = eff_cnt + 16'd1;
                if (last)
                    state_d = ST_DONE;
            end
        end
    end

    // State, shadow config, counters and the short-frame pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            start_q     <= DEF_START_INDEX;
            stop_q      <= DEF_STOP_INDEX;
            num_q       <= DEF_INDEX_NUM;
            idx_next_q  <= 16'd0;
            emit_cnt_q  <= 16'd0;
            frame_cnt_q <= 16'd0;
            short_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            emit_cnt_q <= emit_cnt_d;
            short_q    <= pt_xfer && i_pt_sof && state_q == ST_STREAM && emit_cnt_q != 16'd0;
            if (pt_xfer) begin
                idx_next_q <= (cur_idx >= IDX_LIMIT) ? IDX_LIMIT : cur_idx + 16'd1;
                if (i_pt_sof) begin
                    start_q <= i_start_index;
                    stop_q  <= i_stop_index;
                    num_q   <= i_index_num;
                end
            end
            if (emit && last)
                frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign o_frame_cnt = frame_cnt_q;
    assign o_short_err = short_q;

    win_out_reg #(.DATA_W(DATA_W)) u_out_reg (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (emit),
        .i_sof   (eff_cnt == 16'd0),
        .i_eof   (last),
        .i_index (cur_idx),
        .i_data  (i_pt_data),
        .i_ready (i_win_ready),
        .o_valid (o_win_valid),
        .o_sof   (o_win_sof),
        .o_eof   (o_win_eof),
        .o_index (o_win_index),
        .o_data  (o_win_data)
    );

endmodule

// File: tb/tb_scan_index_window.sv
// tb/tb_scan_index_window.sv - randomized self-checking bench for scan_index_window
module tb_scan_index_window;

    localparam int DATA_W    = 32;
    localparam int INDEX_MAX = 7200;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic [15:0]       i_start_index = '0, i_stop_index = '0, i_index_num = '0;
    logic              i_pt_valid = 1'b0, i_pt_sof = 1'b0;
    logic [DATA_W-1:0] i_pt_data = '0;
    logic              o_pt_ready, o_win_valid, o_win_sof, o_win_eof;
    logic [15:0]       o_win_index;
    logic [DATA_W-1:0] o_win_data;
    logic              i_win_ready = 1'b1;
    logic [15:0]       o_frame_cnt;
    logic              o_short_err;

    scan_index_window #(.DATA_W(DATA_W), .INDEX_MAX(INDEX_MAX)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_start_index(i_start_index), .i_stop_index(i_stop_index), .i_index_num(i_index_num),
        .i_pt_valid(i_pt_valid), .i_pt_sof(i_pt_sof), .i_pt_data(i_pt_data),
        .o_pt_ready(o_pt_ready), .o_win_valid(o_win_valid), .o_win_sof(o_win_sof),
        .o_win_eof(o_win_eof), .o_win_index(o_win_index), .o_win_data(o_win_data),
        .i_win_ready(i_win_ready), .o_frame_cnt(o_frame_cnt), .o_short_err(o_short_err)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        int          idx;
        logic [31:0] data;
        bit          sof;
        bit          eof;
    } exp_t;

    exp_t exp_q[$];
    bit   m_open = 0;
    int   m_start, m_stop, m_num, m_emitted, m_next_idx = 0, m_frames = 0;
    bit   exp_short = 0;
    bit   prev_stall = 0;
    logic [15:0] prev_idx;
    logic [31:0] prev_data;
    int   sc_out = 0, short_seen = 0, cyc = 0;

    function automatic bit model_inwin(input int i, input int s, input int e);
        if (s <= e) return (i >= s) && (i <= e);
        return (i >= s) || (i <= e);
    endfunction

    // Reference: a frame opens on sof and takes in-window points until num are emitted.
    task automatic model_point(input bit sof, input int st, input int sp, input int nm,
                               input logic [31:0] d, output bit short_o);
        int   i;
        exp_t e;
        short_o = 0;
        if (sof) begin
            if (m_open && m_emitted > 0) short_o = 1;
            m_start = st; m_stop = sp; m_num = nm;
            m_open = 1; m_emitted = 0; i = 0;
        end else begin
            i = m_next_idx;
        end
        m_next_idx = (i + 1 > INDEX_MAX) ? INDEX_MAX : i + 1;
        if (m_open && i < INDEX_MAX && model_inwin(i, m_start, m_stop) && m_emitted < m_num) begin
            e.idx = i; e.data = d; e.sof = (m_emitted == 0); e.eof = (m_emitted + 1 == m_num);
            exp_q.push_back(e);
            m_emitted++;
            if (m_emitted == m_num) begin
                m_frames = (m_frames + 1) % 65536;
                m_open = 0;
            end
        end
    endtask

    // One clock: sample just after the falling edge inputs settle, then advance.
    task automatic step(output bit in_x);
        bit   out_x, sh;
        bit   full;
        exp_t e;
        #1;
        full  = (exp_q.size() != 0);
        out_x = full && i_win_ready;
        in_x  = i_pt_valid && (!full || i_win_ready);
        check("win_valid", o_win_valid, full);
        check("pt_ready", o_pt_ready, !full || i_win_ready);
        check("short_err", o_short_err, exp_short);
        if (o_short_err) short_seen++;
        if (prev_stall) begin
            check("stall_index", o_win_index, prev_idx);
            check("stall_data", o_win_data, prev_data);
        end
        if (out_x) begin
            e = exp_q.pop_front();
            check("out_index", o_win_index, e.idx);
            check("out_data", o_win_data, e.data);
            check("out_sof", o_win_sof, e.sof);
            check("out_eof", o_win_eof, e.eof);
            sc_out++;
        end
        prev_stall = o_win_valid && !i_win_ready;
        prev_idx   = o_win_index;
        prev_data  = o_win_data;
        exp_short  = 0;
        if (in_x) begin
            model_point(i_pt_sof, i_start_index, i_stop_index, i_index_num, i_pt_data, sh);
            exp_short = sh;
        end
        @(negedge i_clk);
    endtask

    // Drive one frame: sof on the first point, junk config on every later point.
    task automatic run_frame(input int st, input int sp, input int nm, input int npts, input int rmode);
        int p = 0;
        int guard = 0;
        bit x;
        while (p < npts) begin
            i_pt_valid = ($urandom_range(0, 7) != 0);
            i_pt_sof   = (p == 0);
            i_pt_data  = $urandom;
            if (p == 0) begin
                i_start_index = 16'(st); i_stop_index = 16'(sp); i_index_num = 16'(nm);
            end else begin
                i_start_index = 16'($urandom); i_stop_index = 16'($urandom); i_index_num = 16'($urandom);
            end
            case (rmode)
                0:       i_win_ready = 1'b1;
                1:       i_win_ready = (cyc % 3 == 0);
                default: i_win_ready = 1'($urandom_range(0, 1));
            endcase
            cyc++;
            step(x);
            if (x) p++;
            guard++;
            if (guard > 30000) begin
                check("frame_timeout", 1, 0);
                break;
            end
        end
    endtask

    task automatic drain();
        bit x;
        i_pt_valid  = 1'b0;
        i_win_ready = 1'b1;
        repeat (3) step(x);
        check("drained", exp_q.size(), 0);
    endtask

    initial begin
        bit x;
        int sh0;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        check("rst_win_valid", o_win_valid, 0);
        check("rst_pt_ready", o_pt_ready, 1);
        check("rst_frame_cnt", o_frame_cnt, 0);
        check("rst_short", o_short_err, 0);
        check("rst_fields", {o_win_sof, o_win_eof, o_win_index, o_win_data}, 0);
        @(negedge i_clk);

        sc_out = 0; run_frame(100, 199, 100, 3600, 0); drain();
        check("plain_count", sc_out, 100);
        check("plain_frames", o_frame_cnt, 1);

        sc_out = 0; run_frame(3500, 99, 200, 3600, 0); drain();
        check("wrap_count", sc_out, 200);
        check("wrap_frames", o_frame_cnt, 2);

        sc_out = 0; run_frame(0, 3599, 50, 200, 0); drain();
        check("cap_count", sc_out, 50);
        check("cap_frames", o_frame_cnt, 3);

        sc_out = 0; run_frame(100, 199, 100, 3600, 1); drain();
        check("bp_count", sc_out, 100);
        check("bp_frames", o_frame_cnt, 4);

        sc_out = 0; run_frame(0, 3599, 0, 100, 2); drain();
        check("num0_count", sc_out, 0);
        check("num0_frames", o_frame_cnt, 4);

        sh0 = short_seen;
        sc_out = 0; run_frame(0, 3599, 100, 30, 0);
        run_frame(0, 3599, 20, 40, 0); drain();
        check("short_pulses", short_seen - sh0, 1);
        check("short_count", sc_out, 50);
        check("short_frames", o_frame_cnt, 5);

        for (int r = 0; r < 3; r++) begin
            run_frame($urandom_range(0, 3599), $urandom_range(0, 3599),
                      $urandom_range(1, 400), 800, 2);
            drain();
            check("rand_frames", o_frame_cnt, m_frames);
        end

        sc_out = 0; run_frame(7100, 7300, 500, 7300, 0); drain();
        check("sat_count", sc_out, 100);

        run_frame(0, 3599, 100, 20, 0);
        i_win_ready = 1'b0;
        i_pt_valid  = 1'b1;
        i_pt_sof    = 1'b0;
        repeat (3) step(x);
        check("prerst_valid", o_win_valid, 1);
        i_rst_n    = 1'b0;
        i_pt_valid = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        check("mrst_win_valid", o_win_valid, 0);
        check("mrst_pt_ready", o_pt_ready, 1);
        check("mrst_frame_cnt", o_frame_cnt, 0);
        check("mrst_fields", {o_win_sof, o_win_eof, o_win_index, o_win_data, o_short_err}, 0);
        exp_q.delete();
        m_open = 0; m_next_idx = 0; m_frames = 0; exp_short = 0; prev_stall = 0;
        @(negedge i_clk);
        sc_out = 0;
        i_win_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            i_pt_valid = 1'b1; i_pt_sof = 1'b0; i_pt_data = $urandom;
            step(x);
        end
        check("idle_ignored", sc_out, 0);
        run_frame(10, 20, 5, 30, 2); drain();
        check("post_rst_count", sc_out, 5);
        check("post_rst_frames", o_frame_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
